// File: rtl/frac_mult_scheduler_if.sv
// Request/response handshakes and the multiplier-facing bus of the fracturable multiplier scheduler.
// Vectors use ascending ranges: bit 0 is the MSB, and bit i of a 2-bit vector is port i.
interface frac_mult_scheduler_if;
    logic [0:1]  req_valid;
    logic [0:1]  req_ready;
    logic [0:1]  req_narrow;
    logic [0:15] req0_a;
    logic [0:15] req0_b;
    logic [0:15] req1_a;
    logic [0:15] req1_b;
    logic [0:1]  rsp_valid;
    logic [0:1]  rsp_ready;
    logic [0:31] rsp0_data;
    logic [0:31] rsp1_data;
    logic [0:15] mult_a;
    logic [0:15] mult_b;
    logic [0:0]  mult_mode;
    logic [0:31] mult_out;

    modport master (
        output req_valid, req_narrow, req0_a, req0_b, req1_a, req1_b, rsp_ready, mult_out,
        input  req_ready, rsp_valid, rsp0_data, rsp1_data, mult_a, mult_b, mult_mode
    );

    modport slave (
        input  req_valid, req_narrow, req0_a, req0_b, req1_a, req1_b, rsp_ready, mult_out,
        output req_ready, rsp_valid, rsp0_data, rsp1_data, mult_a, mult_b, mult_mode
    );
endinterface

// File: rtl/frac_mult_scheduler.sv
// Shares one fracturable 16x16 multiplier between two requesters, packing paired 8-bit ops
// into one dual-lane issue and otherwise arbitrating round-robin.
module frac_mult_scheduler #(
    parameter bit          PACK_EN   = 1'b1,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    frac_mult_scheduler_if.slave bus,
    output logic [CNT_WIDTH-1:0] pack_cnt
);
    localparam int unsigned OP_W   = 16;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned RES_W  = 32;

    logic                 s1_valid_q, s1_valid_d;
    logic [0:1]           s1_tag_q, s1_tag_d;
    logic [0:OP_W-1]      s1_a_q, s1_a_d;
    logic [0:OP_W-1]      s1_b_q, s1_b_d;
    logic                 s1_mode_q, s1_mode_d;
    logic [0:1]           rsp_valid_q, rsp_valid_d;
    logic [0:RES_W-1]     rsp0_data_q, rsp0_data_d;
    logic [0:RES_W-1]     rsp1_data_q, rsp1_data_d;
    logic                 rr_q, rr_d;
    logic [CNT_WIDTH-1:0] pack_cnt_q, pack_cnt_d;

    logic             both_v, pack, grant0, grant1;
    logic             s1_move, s1_load, accept;
    logic [0:RES_W-1] narrow0_res, narrow1_res;

    // Pack two narrow ops when allowed, otherwise round-robin among valid ports.
    assign both_v = bus.req_valid[0] & bus.req_valid[1];
    assign pack   = PACK_EN & both_v & bus.req_narrow[0] & bus.req_narrow[1];
    assign grant0 = pack | (both_v ? ~rr_q : bus.req_valid[0]);
    assign grant1 = pack | (both_v ?  rr_q : bus.req_valid[1]);

    // S1 drains only into response registers it owns that are free or being consumed.
    assign s1_move = s1_valid_q
                   & ~(s1_tag_q[0] & rsp_valid_q[0] & ~bus.rsp_ready[0])
                   & ~(s1_tag_q[1] & rsp_valid_q[1] & ~bus.rsp_ready[1]);
    assign s1_load = (~s1_valid_q | s1_move) & ~rst;
    assign accept  = s1_load & (grant0 | grant1);

    assign narrow0_res = {{OP_W{1'b0}}, bus.mult_out[0:OP_W-1]};
    assign narrow1_res = {{OP_W{1'b0}}, bus.mult_out[OP_W:RES_W-1]};

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_tag_d    = s1_tag_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_mode_d   = s1_mode_q;
        rsp_valid_d = rsp_valid_q;
        rsp0_data_d = rsp0_data_q;
        rsp1_data_d = rsp1_data_q;
        rr_d        = rr_q;
        pack_cnt_d  = pack_cnt_q;

        if (bus.rsp_ready[0]) rsp_valid_d[0] = 1'b0;
        if (bus.rsp_ready[1]) rsp_valid_d[1] = 1'b0;
        if (s1_move && s1_tag_q[0]) begin
            rsp_valid_d[0] = 1'b1;
            rsp0_data_d    = s1_mode_q ? narrow0_res : bus.mult_out;
        end
        if (s1_move && s1_tag_q[1]) begin
            rsp_valid_d[1] = 1'b1;
            rsp1_data_d    = s1_mode_q ? narrow1_res : bus.mult_out;
        end

        if (s1_move) s1_valid_d = 1'b0;

        // Narrow port 0 owns lane 0 (MSB byte), narrow port 1 owns lane 1; unused lane is zero.
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_tag_d   = {grant0, grant1};
            if (pack) begin
                s1_mode_d = 1'b1;
                s1_a_d    = {bus.req0_a[LANE_W:OP_W-1], bus.req1_a[LANE_W:OP_W-1]};
                s1_b_d    = {bus.req0_b[LANE_W:OP_W-1], bus.req1_b[LANE_W:OP_W-1]};
                if (pack_cnt_q != '1) pack_cnt_d = pack_cnt_q + CNT_WIDTH'(1);
            end else if (grant0) begin
                s1_mode_d = bus.req_narrow[0];
                s1_a_d    = bus.req_narrow[0] ? {bus.req0_a[LANE_W:OP_W-1], {LANE_W{1'b0}}} : bus.req0_a;
                s1_b_d    = bus.req_narrow[0] ? {bus.req0_b[LANE_W:OP_W-1], {LANE_W{1'b0}}} : bus.req0_b;
                rr_d      = 1'b1;
            end else begin
                s1_mode_d = bus.req_narrow[1];
                s1_a_d    = bus.req_narrow[1] ? {{LANE_W{1'b0}}, bus.req1_a[LANE_W:OP_W-1]} : bus.req1_a;
                s1_b_d    = bus.req_narrow[1] ? {{LANE_W{1'b0}}, bus.req1_b[LANE_W:OP_W-1]} : bus.req1_b;
                rr_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
            rr_q        <= 1'b0;
            pack_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_mode_q   <= s1_mode_d;
            rsp_valid_q <= rsp_valid_d;
            rsp0_data_q <= rsp0_data_d;
            rsp1_data_q <= rsp1_data_d;
            rr_q        <= rr_d;
            pack_cnt_q  <= pack_cnt_d;
        end
    end

    assign bus.req_ready    = {grant0 & s1_load, grant1 & s1_load};
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp0_data    = rsp0_data_q;
    assign bus.rsp1_data    = rsp1_data_q;
    assign bus.mult_a       = s1_a_q;
    assign bus.mult_b       = s1_b_q;
    assign bus.mult_mode[0] = s1_mode_q;
    assign pack_cnt         = pack_cnt_q;
endmodule

// File: tb/tb_frac_mult_scheduler.sv
// Bench for frac_mult_scheduler: vector table, hand sequences for stalls/reset, and a
// per-port response scoreboard fed from accepted requests.
module tb_frac_mult_scheduler;
    typedef struct {
        logic        v0, v1, n0, n1;
        logic [15:0] a0, b0, a1, b1;
        logic        exp_mode;
        logic [15:0] exp_ma;
        logic [31:0] exp_r0, exp_r1;
    } vec_t;

    logic        clk, rst;
    logic [15:0] pack_cnt, pack_cnt_np;
    int          n_cmp, n_bad;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          grant_log[$];

    frac_mult_scheduler_if bus();
    frac_mult_scheduler_if bus_np();

    frac_mult_scheduler #(.PACK_EN(1'b1), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .pack_cnt(pack_cnt));
    frac_mult_scheduler #(.PACK_EN(1'b0), .CNT_WIDTH(16)) dut_np (
        .clk(clk), .rst(rst), .bus(bus_np), .pack_cnt(pack_cnt_np));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier primitive: mode 1 splits into two independent 8x8 lanes (lane 0 = MSB byte).
    function automatic logic [31:0] mult_model(input logic [15:0] a, input logic [15:0] b, input logic m);
        if (m) return {16'(a[15:8]) * 16'(b[15:8]), 16'(a[7:0]) * 16'(b[7:0])};
        return 32'(a) * 32'(b);
    endfunction

    function automatic logic [31:0] exp_prod(input logic [15:0] a, input logic [15:0] b, input logic nw);
        if (nw) return {16'h0000, 16'(a[7:0]) * 16'(b[7:0])};
        return 32'(a) * 32'(b);
    endfunction

    always_comb bus.mult_out    = mult_model(bus.mult_a, bus.mult_b, bus.mult_mode[0]);
    always_comb bus_np.mult_out = mult_model(bus_np.mult_a, bus_np.mult_b, bus_np.mult_mode[0]);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: condition not met at %0t", nm, $time);
    endtask

    // Scoreboard: pop on response handshake before pushing newly accepted requests.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (bus.rsp_valid[0] && bus.rsp_ready[0]) begin
                if (q0.size() == 0) fail_now("sb_rsp0_unexpected");
                else chk("sb_rsp0", bus.rsp0_data, q0.pop_front());
            end
            if (bus.rsp_valid[1] && bus.rsp_ready[1]) begin
                if (q1.size() == 0) fail_now("sb_rsp1_unexpected");
                else chk("sb_rsp1", bus.rsp1_data, q1.pop_front());
            end
            if (bus.req_valid[0] && bus.req_ready[0])
                q0.push_back(exp_prod(bus.req0_a, bus.req0_b, bus.req_narrow[0]));
            if (bus.req_valid[1] && bus.req_ready[1])
                q1.push_back(exp_prod(bus.req1_a, bus.req1_b, bus.req_narrow[1]));
        end
    end

    task automatic apply_vec(input vec_t v, input int idx);
        int n;
        @(posedge clk); #1;
        bus.req_valid[0] = v.v0;  bus.req_valid[1] = v.v1;
        bus.req_narrow[0] = v.n0; bus.req_narrow[1] = v.n1;
        bus.req0_a = v.a0; bus.req0_b = v.b0; bus.req1_a = v.a1; bus.req1_b = v.b1;
        n = 0;
        @(negedge clk);
        while (!((!v.v0 || bus.req_ready[0]) && (!v.v1 || bus.req_ready[1])) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_now($sformatf("v%0d_accept_timeout", idx));
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0; bus.req_valid[1] = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_mult_mode", idx), 32'(bus.mult_mode[0]), 32'(v.exp_mode));
        chk($sformatf("v%0d_mult_a", idx), 32'(bus.mult_a), 32'(v.exp_ma));
        @(negedge clk);
        if (v.v0) begin
            chk($sformatf("v%0d_rsp0_valid", idx), 32'(bus.rsp_valid[0]), 32'd1);
            chk($sformatf("v%0d_rsp0_data", idx), bus.rsp0_data, v.exp_r0);
        end
        if (v.v1) begin
            chk($sformatf("v%0d_rsp1_valid", idx), 32'(bus.rsp_valid[1]), 32'd1);
            chk($sformatf("v%0d_rsp1_data", idx), bus.rsp1_data, v.exp_r1);
        end
    endtask

    task automatic issue_one(input int p, input logic [15:0] a, input logic [15:0] b, input logic nw);
        int n;
        @(posedge clk); #1;
        if (p == 0) begin bus.req0_a = a; bus.req0_b = b; end
        else        begin bus.req1_a = a; bus.req1_b = b; end
        bus.req_narrow[p] = nw;
        bus.req_valid[p]  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready[p] && n < 20);
        if (!bus.req_ready[p]) fail_now($sformatf("issue_p%0d_timeout", p));
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
    endtask

    // Streams n0/n1 random ops on each port, logging grants (2 = packed pair).
    task automatic stream(input int n0, input int n1, input logic nw0, input logic nw1, output int cycles);
        int   left0, left1, cyc;
        logic f0, f1;
        left0 = n0; left1 = n1; cyc = 0;
        @(posedge clk); #1;
        bus.req_narrow[0] = nw0; bus.req_narrow[1] = nw1;
        bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom);
        bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom);
        bus.req_valid[0] = (left0 > 0);
        bus.req_valid[1] = (left1 > 0);
        while ((left0 > 0 || left1 > 0) && cyc < 400) begin
            @(negedge clk);
            f0 = bus.req_valid[0] & bus.req_ready[0];
            f1 = bus.req_valid[1] & bus.req_ready[1];
            if (f0 && f1) grant_log.push_back(2);
            else if (f0)  grant_log.push_back(0);
            else if (f1)  grant_log.push_back(1);
            @(posedge clk); #1;
            cyc++;
            if (f0) begin
                left0--;
                if (left0 > 0) begin bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom); end
                else bus.req_valid[0] = 1'b0;
            end
            if (f1) begin
                left1--;
                if (left1 > 0) begin bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom); end
                else bus.req_valid[1] = 1'b0;
            end
        end
        if (cyc >= 400) fail_now("stream_timeout");
        cycles = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   cyc;
        int   n;
        logic [31:0] held;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1;
        bus.req_valid = 2'b11; bus.req_narrow = 2'b11; bus.rsp_ready = 2'b11;
        bus.req0_a = 16'h00FF; bus.req0_b = 16'h00FF; bus.req1_a = 16'h0003; bus.req1_b = 16'h0005;
        bus_np.req_valid = 2'b00; bus_np.req_narrow = 2'b00; bus_np.rsp_ready = 2'b11;
        bus_np.req0_a = '0; bus_np.req0_b = '0; bus_np.req1_a = '0; bus_np.req1_b = '0;

        //             v0    v1    n0    n1    a0        b0        a1        b1        mode  mult_a    rsp0           rsp1
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0010, 16'h0000, 16'h0000, 1'b0, 16'h1234, 32'h0001_2340, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h00FF, 16'h00FF, 16'h0003, 16'h0005, 1'b1, 16'hFF03, 32'h0000_FE01, 32'h0000_000F};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hAB12, 16'hCD10, 1'b1, 16'h0012, 32'h0,          32'h0000_0120};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h7702, 16'h9903, 16'h0000, 16'h0000, 1'b1, 16'h0200, 32'h0000_0006, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 32'h0,          32'hFFFE_0001};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 16'h0000, 32'h0,          32'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0080, 16'h0080, 16'h00FF, 16'h0001, 1'b1, 16'h80FF, 32'h0000_4000, 32'h0000_00FF};

        // Reset state, with requests presented so ready must still be held low
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid0", 32'(bus.rsp_valid[0]), 32'd0);
        chk("rst_rsp_valid1", 32'(bus.rsp_valid[1]), 32'd0);
        chk("rst_req_ready0", 32'(bus.req_ready[0]), 32'd0);
        chk("rst_req_ready1", 32'(bus.req_ready[1]), 32'd0);
        chk("rst_mult_a", 32'(bus.mult_a), 32'd0);
        chk("rst_mult_b", 32'(bus.mult_b), 32'd0);
        chk("rst_mult_mode", 32'(bus.mult_mode[0]), 32'd0);
        chk("rst_rsp0_data", bus.rsp0_data, 32'd0);
        chk("rst_pack_cnt", 32'(pack_cnt), 32'd0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) apply_vec(vecs[i], i);
        chk("pack_cnt_after_table", 32'(pack_cnt), 32'd2);
        repeat (3) @(negedge clk);
        chk("idle_hold_mult_a", 32'(bus.mult_a), 32'h80FF);
        chk("idle_hold_mult_mode", 32'(bus.mult_mode[0]), 32'd1);

        // Packing disabled: two narrow requests issue alone, one lane each
        @(posedge clk); #1;
        bus_np.req_narrow = 2'b11;
        bus_np.req0_a = 16'h0011; bus_np.req0_b = 16'h0002;
        bus_np.req1_a = 16'h0005; bus_np.req1_b = 16'h0007;
        bus_np.req_valid = 2'b11;
        @(negedge clk);
        chk("np_first_ready0", 32'(bus_np.req_ready[0]), 32'd1);
        chk("np_first_ready1", 32'(bus_np.req_ready[1]), 32'd0);
        @(posedge clk); #1;
        bus_np.req_valid[0] = 1'b0;
        @(negedge clk);
        chk("np_second_ready1", 32'(bus_np.req_ready[1]), 32'd1);
        chk("np_p0_mode", 32'(bus_np.mult_mode[0]), 32'd1);
        chk("np_p0_mult_a", 32'(bus_np.mult_a), 32'h1100);
        chk("np_p0_mult_b", 32'(bus_np.mult_b), 32'h0200);
        @(posedge clk); #1;
        bus_np.req_valid[1] = 1'b0;
        @(negedge clk);
        chk("np_p1_mode", 32'(bus_np.mult_mode[0]), 32'd1);
        chk("np_p1_mult_a", 32'(bus_np.mult_a), 32'h0005);
        chk("np_p1_mult_b", 32'(bus_np.mult_b), 32'h0007);
        chk("np_rsp0_valid", 32'(bus_np.rsp_valid[0]), 32'd1);
        chk("np_rsp0_data", bus_np.rsp0_data, 32'h0000_0022);
        @(negedge clk);
        chk("np_rsp1_valid", 32'(bus_np.rsp_valid[1]), 32'd1);
        chk("np_rsp1_data", bus_np.rsp1_data, 32'h0000_0023);
        chk("np_pack_cnt", 32'(pack_cnt_np), 32'd0);

        // Fill S2 on both ports and S1 behind them, then reset asynchronously mid-cycle
        bus.rsp_ready = 2'b00;
        issue_one(0, 16'h0102, 16'h0304, 1'b0);
        issue_one(1, 16'h0506, 16'h0708, 1'b0);
        issue_one(0, 16'h090A, 16'h0B0C, 1'b0);
        bus.req_narrow[1] = 1'b0;
        bus.req_valid[1]  = 1'b1;
        @(negedge clk);
        chk("full_stall_ready1", 32'(bus.req_ready[1]), 32'd0);
        chk("full_rsp_valid0", 32'(bus.rsp_valid[0]), 32'd1);
        chk("full_rsp_valid1", 32'(bus.rsp_valid[1]), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid0", 32'(bus.rsp_valid[0]), 32'd0);
        chk("midrst_rsp_valid1", 32'(bus.rsp_valid[1]), 32'd0);
        chk("midrst_pack_cnt", 32'(pack_cnt), 32'd0);
        chk("midrst_mult_a", 32'(bus.mult_a), 32'd0);
        chk("midrst_req_ready1", 32'(bus.req_ready[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;

        // Both wide, continuously valid: strict alternation from port 0, one issue per cycle
        grant_log.delete();
        stream(3, 3, 1'b0, 1'b0, cyc);
        chk("rr_cycles", 32'(cyc), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("rr_grant%0d", i), 32'(i < grant_log.size() ? grant_log[i] : -1), 32'(i % 2));
        repeat (4) @(posedge clk);

        // Port 0 response backpressure while port 1 streams narrow ops
        grant_log.delete();
        #1;
        bus.rsp_ready[0] = 1'b0;
        bus.rsp_ready[1] = 1'b1;
        fork
            stream(2, 6, 1'b0, 1'b1, cyc);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.rsp_valid[0] && n < 50);
                if (!bus.rsp_valid[0]) fail_now("bp_rsp0_never_valid");
                held = bus.rsp0_data;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk($sformatf("bp_hold_data%0d", k), bus.rsp0_data, held);
                    chk($sformatf("bp_hold_valid%0d", k), 32'(bus.rsp_valid[0]), 32'd1);
                    chk($sformatf("bp_stall_ready1_%0d", k), 32'(bus.req_ready[1]), 32'd0);
                end
                @(posedge clk); #1;
                bus.rsp_ready[0] = 1'b1;
            end
        join
        chk("bp_grant_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 3; i++)
            chk($sformatf("bp_grant%0d", i), 32'(i < grant_log.size() ? grant_log[i] : -1), 32'(i % 2));

        repeat (10) @(negedge clk);
        chk("sb_q0_drained", 32'(q0.size()), 32'd0);
        chk("sb_q1_drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
